// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and memory_interface signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding core/memory side.
`timescale 1ns/1ps
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_ack;
    logic                  i_err;
    logic [DATA_WIDTH-1:0] i_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [1:0]            d_word_type;
    logic                  d_is_signed;
    logic                  d_ack;
    logic                  d_err;
    logic [DATA_WIDTH-1:0] d_rdata;

    logic [ADDR_WIDTH-1:0] mif_address;
    logic [DATA_WIDTH-1:0] mif_data_in;
    logic                  mif_load;
    logic                  mif_store;
    logic [1:0]            mif_word_type;
    logic                  mif_is_signed;
    logic [DATA_WIDTH-1:0] mif_data_out;
    logic                  mif_output_valid;
    logic                  mif_write_ready;
    logic                  mif_busy;

    modport slave (
        input  i_req, i_addr,
        output i_ack, i_err, i_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_word_type, d_is_signed,
        output d_ack, d_err, d_rdata,
        output mif_address, mif_data_in, mif_load, mif_store, mif_word_type, mif_is_signed,
        input  mif_data_out, mif_output_valid, mif_write_ready, mif_busy
    );

    modport master (
        output i_req, i_addr,
        input  i_ack, i_err, i_rdata,
        output d_req, d_we, d_addr, d_wdata, d_word_type, d_is_signed,
        input  d_ack, d_err, d_rdata,
        input  mif_address, mif_data_in, mif_load, mif_store, mif_word_type, mif_is_signed,
        output mif_data_out, mif_output_valid, mif_write_ready, mif_busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory_interface between the fetch and data ports: data has priority,
// fetch is protected by a starvation counter, and a watchdog bounds every access.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 32,
    parameter int TIMEOUT      = 15,
    parameter int STARVE_LIMIT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus
);

    localparam int WDOG_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int STARVE_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [WDOG_W-1:0]   TIMEOUT_W  = WDOG_W'(TIMEOUT);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [1:0]          WORD_TYPE_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    typedef enum logic {
        OWNER_FETCH,
        OWNER_DATA
    } owner_e;

    state_e                state_q, state_d;
    owner_e                owner_q, owner_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]            wtype_q, wtype_d;
    logic                  signed_q, signed_d;
    logic [STARVE_W-1:0]   starve_q, starve_d;
    logic [WDOG_W-1:0]     wdog_q, wdog_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  grantFetch;
    logic                  completion;
    logic [WDOG_W-1:0]     wdogNext;

    // Fetch only overtakes a pending data request once it has been passed over STARVE_LIMIT times.
    assign grantFetch = bus.i_req && (!bus.d_req || (starve_q == STARVE_MAX));
    assign completion = we_q ? bus.mif_write_ready : bus.mif_output_valid;
    assign wdogNext   = wdog_q + WDOG_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            owner_q  <= OWNER_FETCH;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wtype_q  <= 2'b00;
            signed_q <= 1'b0;
            starve_q <= '0;
            wdog_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wtype_q  <= wtype_d;
            signed_q <= signed_d;
            starve_q <= starve_d;
            wdog_q   <= wdog_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wtype_d  = wtype_q;
        signed_d = signed_q;
        starve_d = starve_q;
        wdog_d   = wdog_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (!bus.mif_busy && (bus.i_req || bus.d_req)) begin
                    state_d = S_ISSUE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (grantFetch) begin
                        owner_d  = OWNER_FETCH;
                        we_d     = 1'b0;
                        addr_d   = bus.i_addr;
                        wdata_d  = '0;
                        wtype_d  = WORD_TYPE_WORD;
                        signed_d = 1'b0;
                        starve_d = '0;
                    end else begin
                        owner_d  = OWNER_DATA;
                        we_d     = bus.d_we;
                        addr_d   = bus.d_addr;
                        wdata_d  = bus.d_wdata;
                        wtype_d  = bus.d_word_type;
                        signed_d = bus.d_is_signed;
                        if (!bus.i_req) begin
                            starve_d = '0;
                        end else if (starve_q != STARVE_MAX) begin
                            starve_d = starve_q + STARVE_W'(1);
                        end
                    end
                end
            end

            S_ISSUE: begin
                wdog_d = '0;
                if (completion) begin
                    state_d = S_RESP;
                    rdata_d = we_q ? '0 : bus.mif_data_out;
                    err_d   = 1'b0;
                end else begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                wdog_d = wdogNext;
                if (completion) begin
                    state_d = S_RESP;
                    rdata_d = we_q ? '0 : bus.mif_data_out;
                    err_d   = 1'b0;
                end else if (wdogNext == TIMEOUT_W) begin
                    state_d = S_RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobes last exactly the ISSUE cycle; address and data stay on the held registers.
    assign bus.mif_load      = (state_q == S_ISSUE) && !we_q;
    assign bus.mif_store     = (state_q == S_ISSUE) && we_q;
    assign bus.mif_address   = addr_q;
    assign bus.mif_data_in   = wdata_q;
    assign bus.mif_word_type = wtype_q;
    assign bus.mif_is_signed = signed_q;

    assign bus.i_ack   = (state_q == S_RESP) && (owner_q == OWNER_FETCH);
    assign bus.d_ack   = (state_q == S_RESP) && (owner_q == OWNER_DATA);
    assign bus.i_err   = bus.i_ack && err_q;
    assign bus.d_err   = bus.d_ack && err_q;
    assign bus.i_rdata = bus.i_ack ? rdata_q : '0;
    assign bus.d_rdata = bus.d_ack ? rdata_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: requester and memory models drive the bus, a
// transaction-level arbitration model fills a scoreboard that a separate monitor drains.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int AW           = 12;
    localparam int DW           = 32;
    localparam int TIMEOUT      = 15;
    localparam int STARVE_LIMIT = 2;

    typedef struct {
        bit            isFetch;
        logic [DW-1:0] rdata;
        bit            err;
    } resp_t;

    logic clk;
    logic rst_n;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    mem_port_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT(TIMEOUT),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    resp_t expQ[$];
    bit    grantLog[$];
    int    checks = 0;
    int    passes = 0;
    int    ackCount = 0;

    bit iEnable, dEnable, forceBoth, busyEnable, forceHang;

    bit          sI, sD, sBusy, sWe, sSigned;
    logic [AW-1:0] sIaddr, sDaddr;
    logic [DW-1:0] sWdata;
    logic [1:0]    sWtype;

    bit            memActive = 0;
    int            memCyc, memLat, memExpLat, modelStarve;
    bit            memOwnI, memStore, memHoldOk;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memHoldData, memLoadData;
    logic [1:0]    memWtype;
    bit            memSigned;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL globalTimeout: simulation still running, expected $finish");
        $fatal(1, "[TB] global timeout");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic applyStimulus(input bit iOn, input bit dOn, input bit both, input bit busyOn, input bit hang);
        iEnable    = iOn;
        dEnable    = dOn;
        forceBoth  = both;
        busyEnable = busyOn;
        forceHang  = hang;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "AckErr"}, 64'({bus.i_ack, bus.d_ack, bus.i_err, bus.d_err}), 64'(0));
        checkOutput({tag, "Rdata"}, 64'({bus.i_rdata, bus.d_rdata}), 64'(0));
        checkOutput({tag, "Strobes"}, 64'({bus.mif_load, bus.mif_store, bus.mif_word_type, bus.mif_is_signed}), 64'(0));
        checkOutput({tag, "MifAddr"}, 64'(bus.mif_address), 64'(0));
        checkOutput({tag, "MifDataIn"}, 64'(bus.mif_data_in), 64'(0));
    endtask

    task automatic drain();
        for (int n = 0; n < 800 && (bus.i_req || bus.d_req || memActive || expQ.size() != 0); n++)
            @(negedge clk);
        checkOutput("drainPending", 64'(expQ.size()), 64'(0));
    endtask

    // Request values as the arbiter saw them at the edge that may have granted.
    always @(posedge clk) begin
        sI      <= bus.i_req;
        sD      <= bus.d_req;
        sBusy   <= bus.mif_busy;
        sIaddr  <= bus.i_addr;
        sDaddr  <= bus.d_addr;
        sWe     <= bus.d_we;
        sWdata  <= bus.d_wdata;
        sWtype  <= bus.d_word_type;
        sSigned <= bus.d_is_signed;
    end

    // Requesters: payload is rescrambled every cycle, so only grant-time values may matter.
    initial begin
        bus.i_req = 0; bus.i_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.d_word_type = 2'b00; bus.d_is_signed = 0; bus.mif_busy = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.i_req = 0;
                bus.d_req = 0;
                bus.mif_busy = 0;
            end else begin
                bus.i_addr      = AW'($urandom);
                bus.d_addr      = AW'($urandom);
                bus.d_we        = 1'($urandom_range(1));
                bus.d_wdata     = $urandom;
                bus.d_word_type = 2'($urandom_range(2));
                bus.d_is_signed = 1'($urandom_range(1));
                if (bus.i_req && bus.i_ack) bus.i_req = 0;
                else if (!bus.i_req && iEnable && (forceBoth || $urandom_range(2) == 0)) bus.i_req = 1;
                if (bus.d_req && bus.d_ack) bus.d_req = 0;
                else if (!bus.d_req && dEnable && (forceBoth || $urandom_range(2) == 0)) bus.d_req = 1;
                bus.mif_busy = busyEnable && ($urandom_range(3) == 0);
            end
        end
    end

    // Memory model plus transaction-level arbitration reference.
    initial begin
        resp_t e;
        int    r;
        bus.mif_output_valid = 0;
        bus.mif_write_ready  = 0;
        bus.mif_data_out     = '0;
        modelStarve = 0;
        forever begin
            @(negedge clk);
            bus.mif_output_valid = 0;
            bus.mif_write_ready  = 0;
            bus.mif_data_out     = $urandom;
            if (!rst_n) begin
                memActive   = 0;
                modelStarve = 0;
            end else begin
                if (memActive) begin
                    if (bus.mif_load || bus.mif_store || bus.mif_address !== memAddr ||
                        bus.mif_word_type !== memWtype || bus.mif_is_signed !== memSigned ||
                        bus.mif_data_in !== memHoldData)
                        memHoldOk = 0;
                    if (bus.i_ack || bus.d_ack) begin
                        checkOutput("ackLatency", 64'(memCyc), 64'(memExpLat));
                        checkOutput("heldStable", 64'(memHoldOk), 64'(1));
                        memActive = 0;
                    end else if (memCyc > TIMEOUT + 4) begin
                        checkOutput("ackWithinBound", 64'(memCyc), 64'(memExpLat));
                        memActive = 0;
                    end
                end else if (bus.mif_load || bus.mif_store) begin
                    checkOutput("strobeHasReq", 64'(sI | sD), 64'(1));
                    checkOutput("noGrantWhileBusy", 64'(sBusy), 64'(0));
                    memOwnI = sI && (!sD || modelStarve == STARVE_LIMIT);
                    if (memOwnI || !sI) modelStarve = 0;
                    else if (modelStarve < STARVE_LIMIT) modelStarve++;
                    memStore  = memOwnI ? 1'b0 : sWe;
                    memAddr   = memOwnI ? sIaddr : sDaddr;
                    memWtype  = memOwnI ? 2'b10 : sWtype;
                    memSigned = memOwnI ? 1'b0 : sSigned;
                    checkOutput("strobeKind", 64'({bus.mif_load, bus.mif_store}), memStore ? 64'(2'b01) : 64'(2'b10));
                    checkOutput("strobeAddr", 64'(bus.mif_address), 64'(memAddr));
                    checkOutput("strobeWordType", 64'(bus.mif_word_type), 64'(memWtype));
                    checkOutput("strobeSigned", 64'(bus.mif_is_signed), 64'(memSigned));
                    if (memStore) checkOutput("storeData", 64'(bus.mif_data_in), 64'(sWdata));
                    grantLog.push_back(memOwnI);
                    r = int'($urandom_range(9));
                    if (forceHang) memLat = -1;
                    else if (r < 6) memLat = r % 4;
                    else if (r < 8) memLat = TIMEOUT;
                    else memLat = -1;
                    memExpLat   = (memLat < 0) ? TIMEOUT + 1 : memLat + 1;
                    memLoadData = $urandom;
                    e.isFetch = memOwnI;
                    e.err     = (memLat < 0);
                    e.rdata   = (memLat < 0 || memStore) ? '0 : memLoadData;
                    expQ.push_back(e);
                    memActive   = 1;
                    memCyc      = 0;
                    memHoldOk   = 1;
                    memHoldData = bus.mif_data_in;
                end
                if (memActive) begin
                    if ($urandom_range(3) == 0) begin
                        if (memStore) bus.mif_output_valid = 1;
                        else bus.mif_write_ready = 1;
                    end
                    if (memCyc == memLat) begin
                        if (memStore) bus.mif_write_ready = 1;
                        else begin
                            bus.mif_output_valid = 1;
                            bus.mif_data_out     = memLoadData;
                        end
                    end
                    memCyc++;
                end
            end
        end
    end

    // Monitor: every acknowledge is matched against the oldest expected response.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (bus.i_ack || bus.d_ack)) begin
                ackCount++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedAck", 64'({bus.i_ack, bus.d_ack}), 64'(0));
                end else begin
                    e = expQ.pop_front();
                    checkOutput("ackOwner", 64'({bus.i_ack, bus.d_ack}), e.isFetch ? 64'(2'b10) : 64'(2'b01));
                    checkOutput("respData", e.isFetch ? 64'(bus.i_rdata) : 64'(bus.d_rdata), 64'(e.rdata));
                    checkOutput("respErr", e.isFetch ? 64'(bus.i_err) : 64'(bus.d_err), 64'(e.err));
                end
            end
        end
    end

    initial begin
        bit expOrder[6];
        int ackBefore;
        expOrder = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        rst_n = 0;
        applyStimulus(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        checkIdleOutputs("reset");
        @(negedge clk);
        rst_n = 1;

        applyStimulus(1, 1, 1, 0, 0);
        for (int n = 0; n < 400 && grantLog.size() < 6; n++) @(negedge clk);
        checkOutput("starveGrantCount", 64'(grantLog.size() >= 6), 64'(1));
        for (int k = 0; k < 6; k++)
            if (k < grantLog.size())
                checkOutput($sformatf("starveOrder%0d", k), 64'(grantLog[k]), 64'(expOrder[k]));
        applyStimulus(0, 0, 0, 0, 0);
        drain();

        applyStimulus(1, 1, 0, 1, 0);
        repeat (3000) @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0);
        drain();

        applyStimulus(0, 1, 0, 0, 1);
        for (int n = 0; n < 100 && !(memActive && memCyc >= 3); n++) @(negedge clk);
        checkOutput("reachedWait", 64'(memActive), 64'(1));
        applyStimulus(0, 0, 0, 0, 0);
        ackBefore = ackCount;
        #2;
        rst_n = 0;
        #1;
        checkIdleOutputs("midReset");
        expQ.delete();
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (30) @(negedge clk);
        checkOutput("noAckAfterReset", 64'(ackCount), 64'(ackBefore));

        applyStimulus(1, 1, 0, 1, 0);
        repeat (300) @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0);
        drain();

        checkOutput("scoreboardEmpty", 64'(expQ.size()), 64'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single memory_interface between the instruction-fetch port and the data (load/store) port of the core. It registers one request at a time, issues it to the memory interface as a one-cycle load/store strobe, waits for completion, and returns data plus a one-cycle acknowledge to the winning requester. Arbitration is fixed-priority for data, with a starvation guard for fetch and a completion watchdog.

## Interface
- ADDR_WIDTH, 12, memory address width
- DATA_WIDTH, 32, requester data width
- TIMEOUT, 15, max cycles in WAIT before an error response
- STARVE_LIMIT, 2, consecutive data grants tolerated while fetch waits
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request, held until i_ack
- i_addr  in  ADDR_WIDTH  fetch address
- i_ack  out  1  one-cycle fetch completion
- i_err  out  1  fetch timed out, valid with i_ack
- i_rdata  out  DATA_WIDTH  fetched word, valid with i_ack
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_word_type  in  2  2'b10 word, 2'b01 halfword, 2'b00 byte
- d_is_signed  in  1  sign-extend loads
- d_ack  out  1  one-cycle data completion
- d_err  out  1  data access timed out, valid with d_ack
- d_rdata  out  DATA_WIDTH  load result, valid with d_ack
- mif_address  out  ADDR_WIDTH  to memory_interface address
- mif_data_in  out  DATA_WIDTH  to memory_interface data_in
- mif_load, mif_store  out  1 each  one-cycle strobes
- mif_word_type  out  2  access size
- mif_is_signed  out  1  sign control
- mif_data_out  in  DATA_WIDTH  load data from memory_interface
- mif_output_valid  in  1  load complete
- mif_write_ready  in  1  store complete
- mif_busy  in  1  memory_interface cannot accept a new strobe

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if mif_busy=0 and any req, pick owner; register addr, wdata, word_type, is_signed, we, owner; -> ISSUE. Else stay.
- Priority: data wins over fetch, except when starve_cnt == STARVE_LIMIT and i_req=1, then fetch wins.
- starve_cnt: +1 on a data grant while i_req=1; cleared on fetch grant or on data grant with i_req=0; saturates at STARVE_LIMIT.
- Fetch access: always word_type 2'b10, is_signed 0, load.
- ISSUE: mif_load (we=0) or mif_store (we=1) high exactly this cycle; mif_address/data/word_type/is_signed driven from registers, held stable through ISSUE and WAIT. Watchdog cleared. -> WAIT, or -> RESP directly if completion pulse seen in ISSUE.
- Completion pulse: mif_output_valid for loads, mif_write_ready for stores; the other signal is ignored. Load data captured from mif_data_out in the completion cycle.
- WAIT: watchdog +1 per cycle; completion -> RESP, err=0. Watchdog reaching TIMEOUT without completion -> RESP, err=1, rdata=0.
- RESP: owner's ack=1 with rdata/err for one cycle; non-owner ack=0. -> IDLE.
- Requester must drop or change req on the edge that ends RESP; req still high in IDLE is treated as a new request.
- Stores return rdata=0.

## Timing
- Reset (reset=0, asynchronous): state IDLE, starve_cnt 0, watchdog 0, all outputs 0 (acks, errs, rdata, mif strobes, mif_address, mif_data_in, mif_word_type, mif_is_signed).
- Reset mid-transaction: transaction abandoned, no ack issued; requester re-requests.
- Minimum latency req-sampled to ack: 2 cycles (IDLE->ISSUE->RESP, completion in ISSUE); typical word load: 3 + memory cycles.
- Back-to-back throughput: one transaction per 3 cycles minimum (RESP->IDLE->ISSUE).
- Simultaneous i_req and d_req in IDLE: data granted unless starvation guard active.
- mif_busy=1 in IDLE blocks arbitration; no strobe while busy.
- Inputs sampled only in IDLE; changes after grant have no effect.

## Test plan
- Single fetch, i_addr=12'h010, memory returns 32'hDEADBEEF with mif_output_valid 2 cycles after mif_load -> mif_word_type=2'b10, i_ack one cycle, i_rdata=32'hDEADBEEF, i_err=0, d_ack=0.
- Signed byte load d_addr=12'h005, d_word_type=2'b00, d_is_signed=1 -> mif_load pulse, mif_is_signed=1, d_rdata=mif_data_out, d_ack one cycle.
- Store d_wdata=32'h12345678, d_we=1 -> mif_store one cycle, mif_data_in=32'h12345678 stable until mif_write_ready, d_ack with d_rdata=0.
- i_req and d_req both held high continuously, STARVE_LIMIT=2 -> grant order D, D, I, D, D, I; no fetch wait beyond 2 data transactions.
- No completion pulse after mif_load -> after TIMEOUT=15 WAIT cycles, d_ack=1, d_err=1, d_rdata=0; next request served normally.
- reset driven low during WAIT -> all outputs 0 immediately, no ack after release; mif_busy=1 with pending req -> no strobe until busy falls.
